// File: rtl/mul_4bit_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding and counter sizing.
package mul_4bit_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StCalc = S_CALC,
        StDone = S_DONE
    } state_t;

    // Iteration counter width; a 1-bit floor keeps WIDTH=1 legal.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Purely combinational ripple-carry adder; at WIDTH=4 it matches the
// existing 4-bit adder bit for bit.
module adder_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic c;

    always_comb begin
        c   = 1'b0;
        Sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            Sum[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end

endmodule

// File: rtl/mul_4bit_seq.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done
// handshake; one adder pass per clock over WIDTH iterations.
module mul_4bit_seq
    import mul_4bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] q_shift;

    assign addend = q_q[0] ? m_q : '0;

    adder_nbit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (acc_q),
        .B    (addend),
        .Sum  (sum),
        .Cout (cout)
    );

    // Carry-out re-enters as the accumulator MSB so no product bit is lost.
    assign acc_shift = {cout, sum[WIDTH-1:1]};
    assign q_shift   = {sum[0], q_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            P       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_q     <= A;
                        q_q     <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_shift;
                    q_q   <= q_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        P       <= {acc_shift, q_shift};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
